// File: rtl/instr_fetch_seq_if.sv
// Fetch-side bus: read address out to the instruction memory, instruction word back,
// and the valid/ready presentation of the captured instruction to the decoder.
interface instr_fetch_seq_if #(
  parameter int N = 512
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] pc_axi;
  logic [31:0]   instr_axi;
  logic [31:0]   instr_out;
  logic          instr_valid;
  logic          instr_ready;

  modport master (
    output pc_axi,
    input  instr_axi,
    output instr_out,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  pc_axi,
    output instr_axi,
    input  instr_out,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: walks the PC from 0 on START, presents each word to the
// decoder over valid/ready, halts on the STOP opcode or on running off the end of memory.
module instr_fetch_seq #(
  parameter int          N       = 512,
  parameter logic [2:0]  STOP_OP = 3'b110,
  localparam int         PW      = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  instr_fetch_seq_if.master  bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [PW:0]        instr_cnt_o
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  localparam logic [PW:0]   CNT_MAX = '1;
  localparam logic [PW-1:0] PC_LAST = PW'(N - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          handshake;

  assign handshake = valid_q && bus.instr_ready;

  // Abort wins over everything else and leaves PC, count and error untouched.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (abort_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (start_i) begin
            state_d = FETCH;
            pc_d    = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
        FETCH: begin
          instr_d = bus.instr_axi;
          valid_d = 1'b1;
          state_d = HOLD;
        end
        HOLD: begin
          if (handshake) begin
            valid_d = 1'b0;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (instr_q[2:0] == STOP_OP) begin
              state_d = HALT;
            end else if (pc_q == PC_LAST) begin
              err_d   = 1'b1;
              state_d = HALT;
            end else begin
              pc_d    = pc_q + 1'b1;
              state_d = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_axi      = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign busy_o          = (state_q == FETCH) || (state_q == HOLD);
  assign done_o          = (state_q == HALT);
  assign err_o           = err_q;
  assign instr_cnt_o     = cnt_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: a 512-word instance runs the matmul program, a 16-word
// instance runs off the end of memory; accepted words are checked against a scoreboard.
module tb_instr_fetch_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic startA = 1'b0;
  logic startB = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b0;

  logic        busyA, doneA, errA;
  logic [9:0]  cntA;
  logic        busyB, doneB, errB;
  logic [4:0]  cntB;

  logic [31:0] memA [512];
  logic [31:0] qA [$];
  logic [31:0] qB [$];

  int nCompared = 0;
  int nMismatched = 0;

  instr_fetch_seq_if #(.N(512)) busA ();
  instr_fetch_seq_if #(.N(16))  busB ();

  assign busA.instr_axi   = memA[busA.pc_axi];
  assign busA.instr_ready = ready;
  assign busB.instr_axi   = 32'h00000004;
  assign busB.instr_ready = ready;

  instr_fetch_seq #(.N(512), .STOP_OP(3'b110)) dutA (
    .clk(clk), .rst(rst), .start_i(startA), .abort_i(abort), .bus(busA),
    .busy_o(busyA), .done_o(doneA), .err_o(errA), .instr_cnt_o(cntA)
  );

  instr_fetch_seq #(.N(16), .STOP_OP(3'b110)) dutB (
    .clk(clk), .rst(rst), .start_i(startB), .abort_i(abort), .bus(busB),
    .busy_o(busyB), .done_o(doneB), .err_o(errB), .instr_cnt_o(cntB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Handshakes are visible at the falling edge before the rising edge that completes them.
  always @(negedge clk) begin
    if (!rst && !abort && busA.instr_valid && busA.instr_ready) begin
      if (qA.size() == 0) checkOutput("scoreboardA_underflow", 32'd1, 32'd0);
      else checkOutput("instrA", busA.instr_out, qA.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && !abort && busB.instr_valid && busB.instr_ready) begin
      if (qB.size() == 0) checkOutput("scoreboardB_underflow", 32'd1, 32'd0);
      else checkOutput("instrB", busB.instr_out, qB.pop_front());
    end
  end

  typedef struct {
    logic       start;
    logic       rdy;
    logic [8:0] expPc;
    logic [9:0] expCnt;
    logic       expValid;
    logic       expBusy;
    logic       expDone;
  } vec_t;

  vec_t vecs [7];

  task automatic applyStimulus(input logic s, input logic r);
    startA = s;
    ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pushProgram();
    qA.delete();
    for (int i = 0; i < 17; i++) qA.push_back(memA[i]);
  endtask

  task automatic pulseStartA();
    applyStimulus(1'b1, ready);
    startA = 1'b0;
  endtask

  task automatic runUntilDoneA(input int bound, output int cycles);
    cycles = 0;
    while (!doneA && cycles < bound) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("doneA_reached", {31'd0, doneA}, 32'd1);
  endtask

  task automatic waitHoldAtA(input int target, input int bound);
    int n = 0;
    while (!(busA.instr_valid && busA.pc_axi == 9'(target)) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("holdA_reached", {31'd0, busA.instr_valid && busA.pc_axi == 9'(target)}, 32'd1);
  endtask

  task automatic checkEndOfProgramA();
    checkOutput("cntA_end", {22'd0, cntA}, 32'd17);
    checkOutput("pcA_end", {23'd0, busA.pc_axi}, 32'd16);
    checkOutput("errA_end", {31'd0, errA}, 32'd0);
    checkOutput("qA_empty", qA.size(), 32'd0);
  endtask

  initial begin
    int cyc;
    int edgeIdx;
    for (int i = 0; i < 512; i++) memA[i] = 32'h0;
    for (int i = 0; i < 16; i++) memA[i] = 32'h0000802A | (32'(i) << 8);
    memA[16] = 32'h00008006;

    vecs[0] = '{1'b1, 1'b1, 9'd0, 10'd0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 9'd0, 10'd0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 9'd1, 10'd1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 9'd1, 10'd1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 9'd2, 10'd2, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 9'd2, 10'd2, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 9'd3, 10'd3, 1'b0, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pcA", {23'd0, busA.pc_axi}, 32'd0);
    checkOutput("rst_instrA", busA.instr_out, 32'd0);
    checkOutput("rst_validA", {31'd0, busA.instr_valid}, 32'd0);
    checkOutput("rst_flagsA", {28'd0, busyA, doneA, errA, 1'b0}, 32'd0);
    checkOutput("rst_cntA", {22'd0, cntA}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Matmul run with READY high; START repeated while busy at PC 2 must be ignored.
    pushProgram();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].start, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_pc", i), {23'd0, busA.pc_axi}, {23'd0, vecs[i].expPc});
      checkOutput($sformatf("vec%0d_cnt", i), {22'd0, cntA}, {22'd0, vecs[i].expCnt});
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, busA.instr_valid}, {31'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d_busy", i), {31'd0, busyA}, {31'd0, vecs[i].expBusy});
      checkOutput($sformatf("vec%0d_done", i), {31'd0, doneA}, {31'd0, vecs[i].expDone});
    end
    startA = 1'b0;
    runUntilDoneA(100, cyc);
    edgeIdx = 6 + cyc;
    checkOutput("done_edge", edgeIdx, 32'd34);
    checkEndOfProgramA();
    checkOutput("busyA_halt", {31'd0, busyA}, 32'd0);

    // Backpressure on word 3.
    pushProgram();
    ready = 1'b1;
    pulseStartA();
    waitHoldAtA(3, 40);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_instr", busA.instr_out, memA[3]);
      checkOutput("bp_pc", {23'd0, busA.pc_axi}, 32'd3);
      checkOutput("bp_valid", {31'd0, busA.instr_valid}, 32'd1);
    end
    ready = 1'b1;
    runUntilDoneA(100, cyc);
    checkEndOfProgramA();

    // Abort while holding word 5.
    pushProgram();
    pulseStartA();
    waitHoldAtA(5, 40);
    ready = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort_valid", {31'd0, busA.instr_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busyA}, 32'd0);
    checkOutput("abort_done", {31'd0, doneA}, 32'd0);
    checkOutput("abort_pc", {23'd0, busA.pc_axi}, 32'd5);
    checkOutput("abort_cnt", {22'd0, cntA}, 32'd5);
    pushProgram();
    ready = 1'b1;
    pulseStartA();
    checkOutput("restart_pc", {23'd0, busA.pc_axi}, 32'd0);
    checkOutput("restart_cnt", {22'd0, cntA}, 32'd0);
    runUntilDoneA(100, cyc);
    checkEndOfProgramA();

    // Asynchronous reset between edges while holding word 4.
    pushProgram();
    pulseStartA();
    waitHoldAtA(4, 40);
    ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", {31'd0, busA.instr_valid}, 32'd0);
    checkOutput("arst_pc", {23'd0, busA.pc_axi}, 32'd0);
    checkOutput("arst_instr", busA.instr_out, 32'd0);
    checkOutput("arst_flags", {29'd0, busyA, doneA, errA}, 32'd0);
    checkOutput("arst_cnt", {22'd0, cntA}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushProgram();
    ready = 1'b1;
    pulseStartA();
    runUntilDoneA(100, cyc);
    checkEndOfProgramA();

    // Program without STOP on the 16-word instance must flag an overrun.
    qB.delete();
    for (int i = 0; i < 16; i++) qB.push_back(32'h00000004);
    startB = 1'b1;
    @(posedge clk);
    #1;
    startB = 1'b0;
    cyc = 0;
    while (!doneB && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("doneB", {31'd0, doneB}, 32'd1);
    checkOutput("errB", {31'd0, errB}, 32'd1);
    checkOutput("pcB", {28'd0, busB.pc_axi}, 32'd15);
    checkOutput("cntB", {27'd0, cntB}, 32'd16);
    checkOutput("qB_empty", qB.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
